xa_bf_beam_sched_00: RTL and testbench

Beam scheduler for the beam-forming delay-calculation datapath (`xa_bf_dly_calc_00`).
- Holds a per-beam direction-vector table written by the host.
- On each ping, steps through beams `0..P_beam_num-1`. For each beam it loads (x,y,z), holds them stable on the datapath inputs and pulses beam start. The beam is complete once `P_stave_num` channel-start pulses have returned.
- Gates position-table and direction-table writes so the host cannot alter tables mid-ping.

---
 rtl/xa_bf_pkg.sv | 22 ++
 rtl/xa_bf_dir_tbl_00.sv | 25 ++
 rtl/xa_bf_beam_sched_00.sv | 228 ++++++++++++++++++++++
 tb/tb_xa_bf_beam_sched_00.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xa_bf_pkg.sv
// Shared definitions for the beam-forming scheduler: FSM encoding, table geometry
// and o_err bit positions.
package xa_bf_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_RUN,
      S_GAP,
      S_DONE
   } state_t;

   localparam int unsigned C_DIR_WORDS = 3;
   localparam int unsigned C_TBL_DEPTH = 768;
   localparam int unsigned C_ADDR_W    = 10;

   localparam int unsigned C_ERR_PING = 0;
   localparam int unsigned C_ERR_WDT  = 1;
   localparam int unsigned C_ERR_DROP = 2;

endpackage

// File: rtl/xa_bf_dir_tbl_00.sv
// Direction-vector table: simple dual-port synchronous RAM, 768x32, 1-cycle read.
// Contents are deliberately not reset so vectors survive a scheduler reset.
module xa_bf_dir_tbl_00
   import xa_bf_pkg::*;
(
   input  logic                clk,
   input  logic                wr_en,
   input  logic [C_ADDR_W-1:0] wr_addr,
   input  logic [31:0]         wr_data,
   input  logic                rd_en,
   input  logic [C_ADDR_W-1:0] rd_addr,
   output logic [31:0]         rd_data
);

   logic [31:0] mem [C_TBL_DEPTH];
   logic [31:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/xa_bf_beam_sched_00.sv
// Beam scheduler: walks the beams of a ping, loads x/y/z, pulses beam start and
// counts channel-start returns. Optional watchdog under macro XA_BF_SCHED_WDT_EN.
module xa_bf_beam_sched_00
   import xa_bf_pkg::*;
#(
   parameter logic [10:0] P_stave_num = 11'd250,
   parameter logic [8:0]  P_beam_num  = 9'd64,
   parameter logic [7:0]  P_gap       = 8'd4,
   parameter logic [15:0] P_wdt_lmt   = 16'd2048
) (
   input  logic        i_clk156m,
   input  logic        i_arst_n,
   input  logic        i_ping_start,
   input  logic        i_err_clr,
   input  logic [31:0] i_dir_wr_data,
   input  logic        i_dir_wr_en,
   input  logic [31:0] i_pos_wr_data,
   input  logic        i_pos_wr_en,
   input  logic        i_ch_start0,
   input  logic        i_ch_start1,
   output logic [31:0] o_bf_dir_vector_ss_x,
   output logic [31:0] o_bf_dir_vector_ss_y,
   output logic [31:0] o_bf_dir_vector_ss_z,
   output logic        o_bm_start,
   output logic [31:0] o_pos_wr_data,
   output logic        o_pos_wr_en,
   output logic [7:0]  o_beam_idx,
   output logic        o_beam_done,
   output logic        o_ping_done,
   output logic        o_busy,
   output logic [2:0]  o_err
);

   state_t              state_q, state_d;
   logic [1:0]          sub_q, sub_d;
   logic [7:0]          beam_q, beam_d;
   logic [10:0]         cnt_q, cnt_d;
   logic [7:0]          gap_q, gap_d;
   logic [31:0]         x_q, x_d, y_q, y_d, z_q, z_d;
   logic                bm_start_q, bm_start_d;
   logic                beam_done_q, beam_done_d;
   logic                ping_done_q, ping_done_d;
   logic                busy_q, busy_d;
   logic [2:0]          err_q, err_d;
   logic                pos_en_q, pos_en_d;
   logic [31:0]         pos_data_q, pos_data_d;
   logic [C_ADDR_W-1:0] waddr_q, waddr_d;

   logic                tbl_we, tbl_re;
   logic [C_ADDR_W-1:0] tbl_raddr;
   logic [31:0]         tbl_rdata;
   logic [11:0]         cnt_sum;
   logic                ch_any;

`ifdef XA_BF_SCHED_WDT_EN
   logic [15:0] wdt_q, wdt_d;
`else
   logic unused_wdt;
   assign unused_wdt = ^P_wdt_lmt;
`endif

   xa_bf_dir_tbl_00 u_dir_tbl (
      .clk     (i_clk156m),
      .wr_en   (tbl_we),
      .wr_addr (waddr_q),
      .wr_data (i_dir_wr_data),
      .rd_en   (tbl_re),
      .rd_addr (tbl_raddr),
      .rd_data (tbl_rdata)
   );

   assign ch_any    = i_ch_start0 | i_ch_start1;
   assign cnt_sum   = {1'b0, cnt_q} + {11'b0, i_ch_start0} + {11'b0, i_ch_start1};
   assign tbl_raddr = ({2'b0, beam_q} * 10'(C_DIR_WORDS)) + {8'b0, sub_q};

   always_comb begin
      state_d     = state_q;
      sub_d       = sub_q;
      beam_d      = beam_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      beam_done_d = 1'b0;
      ping_done_d = 1'b0;
      tbl_re      = 1'b0;
      err_d       = i_err_clr ? '0 : err_q;
      pos_en_d    = i_pos_wr_en & ~busy_q;
      pos_data_d  = i_pos_wr_data;

      // Direction writes only land while idle; the address rewinds whenever enable drops.
      tbl_we  = i_dir_wr_en & ~busy_q & (state_q == S_IDLE) & (waddr_q < 10'(C_TBL_DEPTH));
      waddr_d = i_dir_wr_en ? (tbl_we ? waddr_q + 10'd1 : waddr_q) : '0;

      if (busy_q & (i_pos_wr_en | i_dir_wr_en)) err_d[C_ERR_DROP] = 1'b1;

      if (i_ping_start) begin
         if (state_q == S_IDLE && !busy_q && !i_pos_wr_en && !i_dir_wr_en) begin
            state_d = S_LOAD;
            sub_d   = '0;
            beam_d  = '0;
         end else begin
            err_d[C_ERR_PING] = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: ;
         S_LOAD: begin
            // Reads go out on sub 0..2; data returns one cycle later on sub 1..3.
            tbl_re = (sub_q < 2'(C_DIR_WORDS));
            case (sub_q)
               2'd1:    x_d = tbl_rdata;
               2'd2:    y_d = tbl_rdata;
               2'd3:    z_d = tbl_rdata;
               default: ;
            endcase
            sub_d = sub_q + 2'd1;
            if (sub_q == 2'(C_DIR_WORDS)) state_d = S_START;
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_sum[10:0];
            if (cnt_sum >= {1'b0, P_stave_num}) begin
               beam_done_d = 1'b1;
               gap_d       = '0;
               state_d     = ({1'b0, beam_q} < (P_beam_num - 9'd1)) ? S_GAP : S_DONE;
            end
`ifdef XA_BF_SCHED_WDT_EN
            else if (!ch_any && (wdt_q + 16'd1 >= P_wdt_lmt)) begin
               err_d[C_ERR_WDT] = 1'b1;
               state_d          = S_IDLE;
            end
`endif
         end
         S_GAP: begin
            if ({1'b0, gap_q} + 9'd1 >= {1'b0, P_gap}) begin
               beam_d  = beam_q + 8'd1;
               sub_d   = '0;
               state_d = S_LOAD;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         S_DONE: begin
            ping_done_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifndef XA_BF_SCHED_WDT_EN
      err_d[C_ERR_WDT] = 1'b0;
`endif

      bm_start_d = (state_d == S_START);
      // Busy covers the ping-done cycle so it falls the cycle after o_ping_done.
      busy_d     = (state_d != S_IDLE) | ping_done_d;
   end

`ifdef XA_BF_SCHED_WDT_EN
   always_comb begin
      wdt_d = wdt_q;
      if (state_q == S_START || ch_any) wdt_d = '0;
      else if (state_q == S_RUN)        wdt_d = wdt_q + 16'd1;
   end

   always_ff @(posedge i_clk156m or negedge i_arst_n) begin
      if (!i_arst_n) wdt_q <= '0;
      else           wdt_q <= wdt_d;
   end
`endif

   always_ff @(posedge i_clk156m or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q     <= S_IDLE;
         sub_q       <= '0;
         beam_q      <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         bm_start_q  <= 1'b0;
         beam_done_q <= 1'b0;
         ping_done_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= '0;
         pos_en_q    <= 1'b0;
         pos_data_q  <= '0;
         waddr_q     <= '0;
      end else begin
         state_q     <= state_d;
         sub_q       <= sub_d;
         beam_q      <= beam_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         bm_start_q  <= bm_start_d;
         beam_done_q <= beam_done_d;
         ping_done_q <= ping_done_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         pos_en_q    <= pos_en_d;
         pos_data_q  <= pos_data_d;
         waddr_q     <= waddr_d;
      end
   end

   assign o_bf_dir_vector_ss_x = x_q;
   assign o_bf_dir_vector_ss_y = y_q;
   assign o_bf_dir_vector_ss_z = z_q;
   assign o_bm_start           = bm_start_q;
   assign o_pos_wr_data        = pos_data_q;
   assign o_pos_wr_en          = pos_en_q;
   assign o_beam_idx           = beam_q;
   assign o_beam_done          = beam_done_q;
   assign o_ping_done          = ping_done_q;
   assign o_busy               = busy_q;
   assign o_err                = err_q;

endmodule

// File: tb/tb_xa_bf_beam_sched_00.sv
// Directed bench for xa_bf_beam_sched_00: 3 beams, 4 staves, gap 4; the watchdog
// section runs only when XA_BF_SCHED_WDT_EN is defined.
module tb_xa_bf_beam_sched_00;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        ping, err_clr, dir_en, pos_en, ch0, ch1;
   logic [31:0] dir_data, pos_data;
   logic [31:0] x, y, z, pos_wr_data;
   logic        bm_start, pos_wr_en, beam_done, ping_done, busy;
   logic [7:0]  beam_idx;
   logic [2:0]  err;

   int checks = 0;
   int errors = 0;
   int bm_cnt = 0;
   int pd_cnt = 0;
   logic [31:0] w [9];

   always #5 clk = ~clk;

   xa_bf_beam_sched_00 #(
      .P_stave_num (11'd4),
      .P_beam_num  (9'd3),
      .P_gap       (8'd4),
      .P_wdt_lmt   (16'd100)
   ) dut (
      .i_clk156m            (clk),
      .i_arst_n             (arst_n),
      .i_ping_start         (ping),
      .i_err_clr            (err_clr),
      .i_dir_wr_data        (dir_data),
      .i_dir_wr_en          (dir_en),
      .i_pos_wr_data        (pos_data),
      .i_pos_wr_en          (pos_en),
      .i_ch_start0          (ch0),
      .i_ch_start1          (ch1),
      .o_bf_dir_vector_ss_x (x),
      .o_bf_dir_vector_ss_y (y),
      .o_bf_dir_vector_ss_z (z),
      .o_bm_start           (bm_start),
      .o_pos_wr_data        (pos_wr_data),
      .o_pos_wr_en          (pos_wr_en),
      .o_beam_idx           (beam_idx),
      .o_beam_done          (beam_done),
      .o_ping_done          (ping_done),
      .o_busy               (busy),
      .o_err                (err)
   );

   always @(negedge clk) begin
      if (bm_start)  bm_cnt++;
      if (ping_done) pd_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic c0, input logic c1);
      ch0 = c0;
      ch1 = c1;
      tick();
      ch0 = 1'b0;
      ch1 = 1'b0;
   endtask

   task automatic wait_bm(input string tag);
      int n = 0;
      while (bm_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(bm_start), 32'd1);
   endtask

   task automatic do_ping();
      ping = 1'b1;
      tick();
      ping = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 9; i++) w[i] = 32'h1000_0000 * 32'(i + 1) + 32'(i);
      arst_n = 1'b0; ping = 1'b0; err_clr = 1'b0; dir_en = 1'b0; pos_en = 1'b0;
      ch0 = 1'b0; ch1 = 1'b0; dir_data = '0; pos_data = '0;
      repeat (2) tick();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bm_start", 32'(bm_start), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_idx", 32'(beam_idx), 32'd0);
      chk("rst_x", x, 32'd0);
      chk("rst_z", z, 32'd0);
      chk("rst_pos_en", 32'(pos_wr_en), 32'd0);
      chk("rst_done", 32'({beam_done, ping_done}), 32'd0);
      arst_n = 1'b1;
      tick();

      // Position write while idle passes through with one cycle of delay.
      pos_en = 1'b1; pos_data = 32'hCAFE_F00D;
      tick();
      pos_en = 1'b0;
      chk("pos_pass_en", 32'(pos_wr_en), 32'd1);
      chk("pos_pass_data", pos_wr_data, 32'hCAFE_F00D);
      tick();
      chk("pos_pass_off", 32'(pos_wr_en), 32'd0);

      for (int i = 0; i < 9; i++) begin
         dir_en = 1'b1; dir_data = w[i];
         tick();
      end
      dir_en = 1'b0;
      tick();

      // Ping with a write enable high is refused.
      ping = 1'b1; pos_en = 1'b1;
      tick();
      ping = 1'b0; pos_en = 1'b0;
      chk("ping_wr_busy", 32'(busy), 32'd0);
      chk("ping_wr_err", 32'(err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr0", 32'(err), 32'd0);

      // Beam 0: timing from ping acceptance.
      do_ping();
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_idx", 32'(beam_idx), 32'd0);
      tick(); tick();
      chk("t3_x", x, w[0]);
      tick();
      chk("t4_y", y, w[1]);
      chk("t4_bm", 32'(bm_start), 32'd0);
      tick();
      chk("t5_z", z, w[2]);
      chk("t5_bm", 32'(bm_start), 32'd1);
      tick();
      chk("t6_bm", 32'(bm_start), 32'd0);
      pulse(1'b1, 1'b0);
      chk("b0_p1", 32'(beam_done), 32'd0);
      pulse(1'b0, 1'b1);
      chk("b0_p2", 32'(beam_done), 32'd0);

      pos_en = 1'b1; pos_data = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("drop_pos_en", 32'(pos_wr_en), 32'd0);
      end
      pos_en = 1'b0;
      tick();
      chk("drop_err", 32'(err), 32'b100);
      chk("run_x_stable", x, w[0]);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("drop_clr", 32'(err), 32'd0);

      pulse(1'b1, 1'b0);
      chk("b0_p3", 32'(beam_done), 32'd0);
      pulse(1'b1, 1'b0);
      chk("b0_done", 32'(beam_done), 32'd1);
      chk("b0_busy", 32'(busy), 32'd1);
      chk("b0_ping_done", 32'(ping_done), 32'd0);
      repeat (3) tick();
      chk("gap_idx0", 32'(beam_idx), 32'd0);
      tick();
      chk("gap_idx1", 32'(beam_idx), 32'd1);
      tick(); tick();
      chk("b1_x", x, w[3]);
      tick();
      chk("b1_y", y, w[4]);
      tick();
      chk("b1_bm", 32'(bm_start), 32'd1);
      chk("b1_x_start", x, w[3]);
      chk("b1_z", z, w[5]);
      tick();

      // Beam 1: rejected ping mid-run, then two double-pulse cycles.
      do_ping();
      chk("run_ping_err", 32'(err), 32'd1);
      chk("run_ping_idx", 32'(beam_idx), 32'd1);
      pulse(1'b1, 1'b1);
      chk("b1_dbl1", 32'(beam_done), 32'd0);
      pulse(1'b1, 1'b1);
      chk("b1_dbl2", 32'(beam_done), 32'd1);

      wait_bm("b2_bm");
      chk("b2_idx", 32'(beam_idx), 32'd2);
      chk("b2_x", x, w[6]);
      chk("b2_y", y, w[7]);
      chk("b2_z", z, w[8]);
      tick();
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
      chk("b2_p3", 32'(beam_done), 32'd0);
      pulse(1'b0, 1'b1);
      chk("b2_done", 32'(beam_done), 32'd1);
      chk("b2_pd_early", 32'(ping_done), 32'd0);
      tick();
      chk("pd_pulse", 32'(ping_done), 32'd1);
      chk("pd_busy", 32'(busy), 32'd1);
      chk("pd_beam_done", 32'(beam_done), 32'd0);
      tick();
      chk("pd_end", 32'(ping_done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("bm_count", 32'(bm_cnt), 32'd3);
      chk("pd_count", 32'(pd_cnt), 32'd1);
      chk("err_sticky", 32'(err), 32'd1);

      // Clear and a new set in the same cycle: set wins.
      err_clr = 1'b1; ping = 1'b1; pos_en = 1'b1;
      tick();
      ping = 1'b0; pos_en = 1'b0;
      chk("set_wins", 32'(err), 32'd1);
      tick();
      err_clr = 1'b0;
      chk("clr_only", 32'(err), 32'd0);

      // Reset in the middle of a run.
      do_ping();
      wait_bm("rst_bm");
      tick();
      pulse(1'b1, 1'b0);
      do_ping();
      chk("pre_rst_err", 32'(err), 32'd1);
      arst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_x", x, 32'd0);
      chk("mid_rst_idx", 32'(beam_idx), 32'd0);
      tick();
      arst_n = 1'b1;
      tick();

      do_ping();
      for (int b = 0; b < 3; b++) begin
         wait_bm("replay_bm");
         chk("replay_idx", 32'(beam_idx), 32'(b));
         chk("replay_x", x, w[3*b]);
         chk("replay_y", y, w[3*b+1]);
         chk("replay_z", z, w[3*b+2]);
         tick();
         pulse(1'b1, 1'b1);
         pulse(1'b1, 1'b1);
         chk("replay_done", 32'(beam_done), 32'd1);
      end
      tick();
      chk("replay_pd", 32'(ping_done), 32'd1);
      tick();
      chk("replay_idle", 32'(busy), 32'd0);

`ifdef XA_BF_SCHED_WDT_EN
      do_ping();
      wait_bm("wdt_bm");
      repeat (98) tick();
      chk("wdt_busy_hold", 32'(busy), 32'd1);
      repeat (3) tick();
      chk("wdt_busy_drop", 32'(busy), 32'd0);
      chk("wdt_err", 32'(err), 32'b010);
      chk("wdt_no_pd", 32'(pd_cnt), 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
